// File: rtl/tri_st_mult_boothenc_if.sv
// Operand offer and Booth row-group bus between the XU issue logic
// and the radix-4 Booth row array.
interface tri_st_mult_boothenc_if;
    logic        ex_val;
    logic        ex_rdy;
    logic        ex_flush;
    logic        ex_y_signed;
    logic        ex_x_signed;
    logic [0:31] ex_y;
    logic [0:31] ex_x;
    logic        row_hold;
    logic [0:3]  row_val;
    logic [0:3]  row_s_neg;
    logic [0:3]  row_s_x;
    logic [0:3]  row_s_x2;
    logic        row_sign_bit_adj;
    logic [0:31] row_x;
    logic [0:2]  row_grp;
    logic        row_last;

    modport master (
        output ex_val, ex_flush, ex_y_signed, ex_x_signed,
        output ex_y, ex_x, row_hold,
        input  ex_rdy, row_val, row_s_neg, row_s_x, row_s_x2,
        input  row_sign_bit_adj, row_x, row_grp, row_last
    );

    modport slave (
        input  ex_val, ex_flush, ex_y_signed, ex_x_signed,
        input  ex_y, ex_x, row_hold,
        output ex_rdy, row_val, row_s_neg, row_s_x, row_s_x2,
        output row_sign_bit_adj, row_x, row_grp, row_last
    );
endinterface

// File: rtl/tri_st_mult_boothenc.sv
// Sequential radix-4 Booth encoder: emits 17 digits as five groups of
// four row selects, one group per cycle, with hold and flush.
module tri_st_mult_boothenc (
    input logic                   nclk,
    input logic                   rst_n,
    tri_st_mult_boothenc_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [2:0]  grp_q, grp_d;
    logic [34:0] ext_q, ext_d;
    logic [31:0] x_q, x_d;
    logic        sba_q, sba_d;
    logic [3:0]  val_q, val_d;
    logic [3:0]  neg_q, neg_d;
    logic [3:0]  sx_q, sx_d;
    logic [3:0]  sx2_q, sx2_d;
    logic        last_q, last_d;
    logic        rdy;
    logic        accept;
    logic [4:0]  dig;
    logic [2:0]  trip;

    assign rdy = rst_n & ~bus.ex_flush &
                 ((state_q == IDLE) |
                  ((state_q == RUN) & (grp_q == 3'd4) & ~bus.row_hold));
    assign accept = bus.ex_val & rdy;

    always_ff @(posedge nclk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grp_q   <= '0;
            ext_q   <= '0;
            x_q     <= '0;
            sba_q   <= 1'b0;
            val_q   <= '0;
            neg_q   <= '0;
            sx_q    <= '0;
            sx2_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grp_q   <= grp_d;
            ext_q   <= ext_d;
            x_q     <= x_d;
            sba_q   <= sba_d;
            val_q   <= val_d;
            neg_q   <= neg_d;
            sx_q    <= sx_d;
            sx2_q   <= sx2_d;
            last_q  <= last_d;
        end
    end

    // Flush beats acceptance; acceptance at g=4 restarts without a bubble.
    always_comb begin
        state_d = state_q;
        grp_d   = grp_q;
        if (bus.ex_flush) begin
            state_d = IDLE;
            grp_d   = '0;
        end else if (accept) begin
            state_d = RUN;
            grp_d   = '0;
        end else if ((state_q == RUN) && !bus.row_hold) begin
            if (grp_q == 3'd4) begin
                state_d = IDLE;
                grp_d   = '0;
            end else begin
                grp_d = grp_q + 3'd1;
            end
        end
    end

    // ext holds y[-1..33] at bit k+1; outputs are precomputed for grp_d.
    always_comb begin
        ext_d  = ext_q;
        x_d    = x_q;
        sba_d  = sba_q;
        val_d  = '0;
        neg_d  = '0;
        sx_d   = '0;
        sx2_d  = '0;
        last_d = 1'b0;
        dig    = '0;
        trip   = '0;
        if (accept) begin
            ext_d[0]     = 1'b0;
            ext_d[32:1]  = bus.ex_y;
            ext_d[34:33] = {2{bus.ex_y_signed & bus.ex_y[0]}};
            x_d          = bus.ex_x;
            sba_d        = bus.ex_x_signed & bus.ex_x[0];
        end
        if (state_d == RUN) begin
            last_d = (grp_d == 3'd4);
            for (int r = 0; r < 4; r++) begin
                if ((grp_d != 3'd4) || (r == 0)) begin
                    dig  = {grp_d, 2'(r)};
                    trip = ext_d[{dig, 1'b0} +: 3];
                    val_d[2'(3 - r)] = 1'b1;
                    sx_d[2'(3 - r)]  = trip[1] ^ trip[0];
                    sx2_d[2'(3 - r)] = (trip[2] & ~trip[1] & ~trip[0]) |
                                       (~trip[2] & trip[1] & trip[0]);
                    neg_d[2'(3 - r)] = trip[2] & ~(trip[1] & trip[0]);
                end
            end
        end
    end

    assign bus.ex_rdy           = rdy;
    assign bus.row_val          = val_q;
    assign bus.row_s_neg        = neg_q;
    assign bus.row_s_x          = sx_q;
    assign bus.row_s_x2         = sx2_q;
    assign bus.row_sign_bit_adj = sba_q;
    assign bus.row_x            = x_q;
    assign bus.row_grp          = grp_q;
    assign bus.row_last         = last_q;
endmodule

// File: tb/tb_tri_st_mult_boothenc.sv
// Directed bench for the radix-4 Booth encoder, with a product
// scoreboard rebuilt from the emitted row selects.
module tb_tri_st_mult_boothenc;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   pass_cnt = 0;
    int   fail_cnt = 0;
    int   total = 0;
    logic signed [67:0] acc;
    logic [11:0] snap;
    logic [31:0] oy [4];
    logic [31:0] ox [4];
    logic        oys [4];
    logic        oxs [4];

    tri_st_mult_boothenc_if bus ();

    tri_st_mult_boothenc dut (
        .nclk  (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [67:0] obs,
                       input logic [67:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] y, input logic [31:0] x,
                         input logic ys, input logic xs);
        bus.ex_val      = 1'b1;
        bus.ex_y        = y;
        bus.ex_x        = x;
        bus.ex_y_signed = ys;
        bus.ex_x_signed = xs;
    endtask

    task automatic junk;
        bus.ex_y        = $urandom;
        bus.ex_x        = $urandom;
        bus.ex_y_signed = 1'($urandom);
        bus.ex_x_signed = 1'($urandom);
    endtask

    function automatic logic signed [67:0] ext68(input logic [31:0] v,
                                                input logic s);
        return s ? {{36{v[31]}}, v} : {36'b0, v};
    endfunction

    function automatic logic signed [67:0] ref_prod(
        input logic [31:0] y, input logic [31:0] x,
        input logic ys, input logic xs);
        return ext68(y, ys) * ext68(x, xs);
    endfunction

    // Adds digit * 4^d * X for every valid row of the visible group.
    task automatic accum(input logic [31:0] x, input logic xs);
        logic signed [67:0] xv;
        logic signed [67:0] t;
        int d;
        xv = ext68(x, xs);
        for (int r = 0; r < 4; r++) begin
            if (bus.row_val[r]) begin
                d = 4 * int'(bus.row_grp) + r;
                t = bus.row_s_x[r] ? xv :
                    (bus.row_s_x2[r] ? (xv <<< 1) : 68'sd0);
                t = t <<< (2 * d);
                acc = bus.row_s_neg[r] ? acc - t : acc + t;
            end
        end
    endtask

    initial begin
        bus.ex_val = 1'b0;
        bus.ex_flush = 1'b0;
        bus.row_hold = 1'b0;
        bus.ex_y = '0;
        bus.ex_x = '0;
        bus.ex_y_signed = 1'b0;
        bus.ex_x_signed = 1'b0;

        #1 chk("rst_rdy", bus.ex_rdy, 0);
        tick;
        tick;
        chk("rst_val", bus.row_val, 0);
        chk("rst_grp", bus.row_grp, 0);
        chk("rst_x", bus.row_x, 0);
        chk("rst_last", bus.row_last, 0);
        rst_n = 1'b1;
        #1 chk("idle_rdy", bus.ex_rdy, 1);

        // Unsigned all-ones multiplier
        offer(32'hFFFF_FFFF, 32'h1234_5678, 1'b0, 1'b0);
        tick;
        bus.ex_val = 1'b0;
        junk;
        acc = '0;
        chk("a1_g0_val", bus.row_val, 4'b1111);
        chk("a1_g0_neg", bus.row_s_neg, 4'b1000);
        chk("a1_g0_sx", bus.row_s_x, 4'b1000);
        chk("a1_g0_sx2", bus.row_s_x2, 4'b0000);
        chk("a1_g0_x", bus.row_x, 32'h1234_5678);
        chk("a1_g0_sba", bus.row_sign_bit_adj, 0);
        chk("a1_g0_rdy", bus.ex_rdy, 0);
        accum(32'h1234_5678, 1'b0);
        for (int g = 1; g < 4; g++) begin
            tick;
            chk("a1_mid_grp", bus.row_grp, g);
            chk("a1_mid_sel",
                {bus.row_s_neg, bus.row_s_x, bus.row_s_x2}, 0);
            accum(32'h1234_5678, 1'b0);
        end
        tick;
        chk("a1_g4_val", bus.row_val, 4'b1000);
        chk("a1_g4_sx", bus.row_s_x, 4'b1000);
        chk("a1_g4_neg", bus.row_s_neg, 4'b0000);
        chk("a1_g4_last", bus.row_last, 1);
        chk("a1_g4_grp", bus.row_grp, 4);
        chk("a1_g4_rdy", bus.ex_rdy, 1);
        accum(32'h1234_5678, 1'b0);
        chk("a1_prod", acc, ref_prod(32'hFFFF_FFFF, 32'h1234_5678, 0, 0));
        tick;
        chk("a1_done_val", bus.row_val, 0);
        chk("a1_done_last", bus.row_last, 0);

        // Signed minimum multiplier
        offer(32'h8000_0000, 32'h8000_0001, 1'b1, 1'b1);
        tick;
        bus.ex_val = 1'b0;
        acc = '0;
        chk("smin_sba", bus.row_sign_bit_adj, 1);
        for (int g = 0; g < 3; g++) begin
            accum(32'h8000_0001, 1'b1);
            tick;
        end
        chk("smin_g3_neg", bus.row_s_neg, 4'b0001);
        chk("smin_g3_sx2", bus.row_s_x2, 4'b0001);
        chk("smin_g3_sx", bus.row_s_x, 4'b0000);
        accum(32'h8000_0001, 1'b1);
        tick;
        chk("smin_g4_sel", {bus.row_s_neg, bus.row_s_x, bus.row_s_x2}, 0);
        chk("smin_g4_val", bus.row_val, 4'b1000);
        accum(32'h8000_0001, 1'b1);
        chk("smin_prod", acc, ref_prod(32'h8000_0000, 32'h8000_0001, 1, 1));
        tick;

        // Same multiplier, unsigned
        offer(32'h8000_0000, 32'h0000_0003, 1'b0, 1'b0);
        tick;
        bus.ex_val = 1'b0;
        acc = '0;
        for (int g = 0; g < 4; g++) begin
            accum(32'h0000_0003, 1'b0);
            tick;
        end
        chk("umin_g4_sx", bus.row_s_x, 4'b1000);
        chk("umin_g4_neg", bus.row_s_neg, 4'b0000);
        accum(32'h0000_0003, 1'b0);
        chk("umin_prod", acc, ref_prod(32'h8000_0000, 32'h0000_0003, 0, 0));
        tick;

        // Hold for three cycles at group 2
        offer(32'h0000_ABCD, 32'hFFFF_0001, 1'b0, 1'b1);
        tick;
        bus.ex_val = 1'b0;
        acc = '0;
        accum(32'hFFFF_0001, 1'b1);
        tick;
        accum(32'hFFFF_0001, 1'b1);
        tick;
        chk("hold_g2_grp", bus.row_grp, 2);
        snap = {bus.row_s_neg, bus.row_s_x, bus.row_s_x2};
        accum(32'hFFFF_0001, 1'b1);
        bus.row_hold = 1'b1;
        junk;
        for (int h = 0; h < 3; h++) begin
            tick;
            chk("hold_grp", bus.row_grp, 2);
            chk("hold_val", bus.row_val, 4'b1111);
            chk("hold_sel", {bus.row_s_neg, bus.row_s_x, bus.row_s_x2}, snap);
            chk("hold_rdy", bus.ex_rdy, 0);
        end
        bus.row_hold = 1'b0;
        tick;
        chk("hold_g3_grp", bus.row_grp, 3);
        accum(32'hFFFF_0001, 1'b1);
        tick;
        chk("hold_g4_grp", bus.row_grp, 4);
        chk("hold_g4_rdy", bus.ex_rdy, 1);
        accum(32'hFFFF_0001, 1'b1);
        chk("hold_prod", acc, ref_prod(32'h0000_ABCD, 32'hFFFF_0001, 0, 1));
        tick;

        // Flush at group 1 with a competing offer
        offer(32'h1357_9BDF, 32'h2468_ACE0, 1'b1, 1'b0);
        tick;
        tick;
        chk("fl_g1_grp", bus.row_grp, 1);
        bus.ex_flush = 1'b1;
        offer(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b0);
        #1 chk("fl_rdy", bus.ex_rdy, 0);
        tick;
        chk("fl_val", bus.row_val, 0);
        chk("fl_grp", bus.row_grp, 0);
        bus.ex_flush = 1'b0;
        #1 chk("fl_idle_rdy", bus.ex_rdy, 1);
        tick;
        chk("fl_new_val", bus.row_val, 4'b1111);
        chk("fl_new_x", bus.row_x, 32'h0000_0007);

        // Reset in the middle of an operation
        tick;
        rst_n = 1'b0;
        #1 chk("mrst_rdy0", bus.ex_rdy, 0);
        tick;
        chk("mrst_val", bus.row_val, 0);
        chk("mrst_rdy1", bus.ex_rdy, 0);
        tick;
        chk("mrst_x", bus.row_x, 0);
        rst_n = 1'b1;
        bus.ex_val = 1'b0;
        #1 chk("mrst_rel_rdy", bus.ex_rdy, 1);
        tick;
        tick;
        chk("mrst_after_val", bus.row_val, 0);

        // Back-to-back with ex_val held high
        for (int i = 0; i < 4; i++) begin
            oy[i]  = $urandom;
            ox[i]  = $urandom;
            oys[i] = 1'(i & 1);
            oxs[i] = 1'(i >> 1);
        end
        oy[1][31] = 1'b1;
        ox[3][31] = 1'b1;
        offer(oy[0], ox[0], oys[0], oxs[0]);
        tick;
        for (int i = 0; i < 4; i++) begin
            acc = '0;
            chk("b2b_x", bus.row_x, ox[i]);
            for (int g = 0; g < 5; g++) begin
                chk("b2b_grp", bus.row_grp, g);
                chk("b2b_rdy", bus.ex_rdy, (g == 4));
                chk("b2b_val", bus.row_val, (g == 4) ? 4'b1000 : 4'b1111);
                accum(ox[i], oxs[i]);
                if (g < 4) begin
                    junk;
                end else begin
                    chk("b2b_prod", acc, ref_prod(oy[i], ox[i], oys[i], oxs[i]));
                    if (i < 3) offer(oy[i+1], ox[i+1], oys[i+1], oxs[i+1]);
                    else bus.ex_val = 1'b0;
                end
                tick;
            end
        end
        chk("b2b_end_val", bus.row_val, 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
